// File: rtl/otter_mem_pkg.sv
// Shared types and constants for the memory-stage load/store unit.
// The optional misalignment trap is controlled by the LSU_MISALIGN_TRAP_EN macro.
package otter_mem_pkg;

    typedef enum logic [1:0] {
        BYTE = 2'b00,
        HALF = 2'b01,
        WORD = 2'b10
    } mem_size_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        REQ  = 2'b01,
        DONE = 2'b10
    } lsu_state_t;

    // ResultSrcM encoding that marks a load
    localparam logic [1:0] RESULT_SRC_MEM_DEF = 2'b01;

    // Byte-enable patterns for a lane-0 access of each size
    localparam logic [3:0] BE_BYTE = 4'b0001;
    localparam logic [3:0] BE_HALF = 4'b0011;
    localparam logic [3:0] BE_WORD = 4'b1111;

    // Size code 2'b11 has no meaning of its own and behaves as a word
    function automatic mem_size_t decodeSize(input logic [1:0] code);
        mem_size_t s;
        case (code)
            2'b00:   s = BYTE;
            2'b01:   s = HALF;
            default: s = WORD;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/mem_stage_lsu_if.sv
// Data-bus bundle between the M-stage LSU (master) and the memory (slave).
interface mem_stage_lsu_if;
    logic        BusReq;
    logic        BusWe;
    logic [31:0] BusAddr;
    logic [31:0] BusWData;
    logic [3:0]  BusBe;
    logic        BusAck;
    logic [31:0] BusRData;

    modport master (
        output BusReq, BusWe, BusAddr, BusWData, BusBe,
        input  BusAck, BusRData
    );

    modport slave (
        input  BusReq, BusWe, BusAddr, BusWData, BusBe,
        output BusAck, BusRData
    );
endinterface

// File: rtl/lsu_align.sv
// Combinational lane formatting: store byte enables / replicated write data,
// and load extraction with sign or zero extension. Offsets finer than the
// access size are aligned down.
module lsu_align
    import otter_mem_pkg::*;
(
    input  logic [1:0]  AddrLo,
    input  mem_size_t   Size,
    input  logic        ZeroExt,
    input  logic [31:0] StoreData,
    input  logic [31:0] RawRData,
    output logic [3:0]  ByteEn,
    output logic [31:0] LaneWData,
    output logic [31:0] LoadData
);
    logic [1:0]  offset;
    logic [31:0] shifted;

    // Lane selection, store replication and load extension per access size
    always_comb begin
        offset    = 2'b00;
        ByteEn    = BE_WORD;
        LaneWData = StoreData;
        case (Size)
            BYTE: begin
                offset    = AddrLo;
                ByteEn    = BE_BYTE << offset;
                LaneWData = {4{StoreData[7:0]}};
            end
            HALF: begin
                offset    = {AddrLo[1], 1'b0};
                ByteEn    = BE_HALF << offset;
                LaneWData = {2{StoreData[15:0]}};
            end
            default: begin
                offset    = 2'b00;
                ByteEn    = BE_WORD;
                LaneWData = StoreData;
            end
        endcase
        shifted = RawRData >> {offset, 3'b000};
        case (Size)
            BYTE:    LoadData = ZeroExt ? {24'd0, shifted[7:0]}
                                        : {{24{shifted[7]}}, shifted[7:0]};
            HALF:    LoadData = ZeroExt ? {16'd0, shifted[15:0]}
                                        : {{16{shifted[15]}}, shifted[15:0]};
            default: LoadData = shifted;
        endcase
    end
endmodule

// File: rtl/mem_stage_lsu.sv
// Memory-stage load/store unit: issues one req/ack bus transaction per
// M-stage access, stalls the pipeline until it retires, and aborts with a
// one-cycle BusErrM pulse if no ack arrives within TIMEOUT_CYCLES.
// Optional feature macro: LSU_MISALIGN_TRAP_EN (adds MisalignM and
// suppresses misaligned accesses instead of aligning them down).
module mem_stage_lsu
    import otter_mem_pkg::*;
#(
    parameter int         TIMEOUT_CYCLES = 255,
    parameter logic [1:0] RESULT_SRC_MEM = RESULT_SRC_MEM_DEF
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  MemWriteM,
    input  logic [1:0]            ResultSrcM,
    input  logic [31:0]           ALUResultM,
    input  logic [31:0]           WriteDataM,
    input  logic [1:0]            MemSizeM,
    input  logic                  MemSignM,
    mem_stage_lsu_if.master       bus,
    output logic [31:0]           ReadDataM,
    output logic                  StallM,
    output logic                  BusErrM
`ifdef LSU_MISALIGN_TRAP_EN
    ,
    output logic                  MisalignM
`endif
);
    localparam int             CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYCLES);

    lsu_state_t       stateReg, stateNext;
    logic [CNT_W-1:0] toCount;
    logic [1:0]       offReg;
    mem_size_t        sizeReg;
    logic             zextReg;

    mem_size_t   sizeM;
    logic        access, misaligned, issue, timeoutHit;
    logic [1:0]  alignOff;
    mem_size_t   alignSize;
    logic        alignZext;
    logic [3:0]  laneBe;
    logic [31:0] laneWData, loadData;

    assign sizeM  = decodeSize(MemSizeM);
    assign access = MemWriteM | (ResultSrcM == RESULT_SRC_MEM);

`ifdef LSU_MISALIGN_TRAP_EN
    assign misaligned = ((sizeM == HALF) & ALUResultM[0]) |
                        ((sizeM == WORD) & (ALUResultM[1:0] != 2'b00));
    assign MisalignM  = (stateReg == IDLE) & access & misaligned;
`else
    assign misaligned = 1'b0;
`endif

    assign issue = access & ~misaligned;

    // In IDLE the formatter sees the live access (store lanes, byte enables);
    // afterwards it sees the latched load info for capturing BusRData.
    assign alignOff  = (stateReg == IDLE) ? ALUResultM[1:0] : offReg;
    assign alignSize = (stateReg == IDLE) ? sizeM : sizeReg;
    assign alignZext = (stateReg == IDLE) ? MemSignM : zextReg;

    lsu_align uAlign (
        .AddrLo    (alignOff),
        .Size      (alignSize),
        .ZeroExt   (alignZext),
        .StoreData (WriteDataM),
        .RawRData  (bus.BusRData),
        .ByteEn    (laneBe),
        .LaneWData (laneWData),
        .LoadData  (loadData)
    );

    assign bus.BusReq = (stateReg == REQ);

    // Next-state logic, stall and timeout detection
    always_comb begin
        stateNext  = stateReg;
        timeoutHit = 1'b0;
        StallM     = 1'b0;
        case (stateReg)
            IDLE: begin
                StallM = issue;
                if (issue) stateNext = REQ;
            end
            REQ: begin
                StallM = 1'b1;
                if (bus.BusAck) begin
                    stateNext = DONE;
                end else if (toCount >= CNT_LAST) begin
                    timeoutHit = 1'b1;
                    stateNext  = DONE;
                end
            end
            DONE:    stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) stateReg <= IDLE;
        else        stateReg <= stateNext;
    end

    // Request latching, load capture, timeout counter and error pulse
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            bus.BusWe    <= 1'b0;
            bus.BusAddr  <= 32'd0;
            bus.BusWData <= 32'd0;
            bus.BusBe    <= 4'd0;
            ReadDataM    <= 32'd0;
            BusErrM      <= 1'b0;
            toCount      <= '0;
            offReg       <= 2'b00;
            sizeReg      <= BYTE;
            zextReg      <= 1'b0;
        end else begin
            BusErrM <= 1'b0;
            if (stateReg == IDLE && issue) begin
                bus.BusWe    <= MemWriteM;
                bus.BusAddr  <= {ALUResultM[31:2], 2'b00};
                bus.BusWData <= laneWData;
                bus.BusBe    <= laneBe;
                offReg       <= ALUResultM[1:0];
                sizeReg      <= sizeM;
                zextReg      <= MemSignM;
                toCount      <= '0;
            end else if (stateReg == REQ) begin
                if (bus.BusAck) begin
                    if (!bus.BusWe) ReadDataM <= loadData;
                end else if (timeoutHit) begin
                    ReadDataM <= 32'd0;
                    BusErrM   <= 1'b1;
                end else if (toCount != CNT_MAX) begin
                    toCount <= toCount + 1'b1;
                end
            end
        end
    end
endmodule
